convolution_filter: RTL and testbench
=====================================

Name: convolution_filter

Overview:
Streaming 2-D image convolution block for the pattern-recognition pipeline. Accepts one unsigned grayscale pixel per handshake in raster order and applies a runtime-programmable signed KERNEL_H x KERNEL_W kernel with zero padding. Emits exactly one saturated unsigned pixel per input pixel, in the same raster order. Sits between the grayscale source and the downstream feature/edge stages.

Parameters:
IMG_WIDTH, 640, pixels per row
IMG_HEIGHT, 480, rows per frame
KERNEL_H, 3, kernel rows (odd, >=1)
KERNEL_W, 3, kernel columns (odd, >=1)
W, 8, pixel and coefficient width in bits
W_FRAC, 0, fractional bits of the kernel coefficients; the sum is arithmetically right-shifted by W_FRAC

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
x_valid  input  1  input pixel valid
x_ready  output  1  block can accept an input pixel
x_data  input  W  unsigned input pixel
y_valid  output  1  output pixel valid
y_ready  input  1  downstream can accept an output pixel
y_data  output  W  unsigned output pixel
kernel  input  signed W x [KERNEL_H][KERNEL_W]  unpacked coefficient array; kernel[0][0] weights the top-left neighbour; sampled live, must be held stable during a frame

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Reset clears row/column counters, line buffers' valid state, flush state, y_valid=0, y_data=0. Reset mid-frame abandons the frame; the next accepted pixel is pixel (0,0).
- Input accepted on x_valid && x_ready. Output transferred on y_valid && y_ready. y_data/y_valid held stable while y_valid && !y_ready.
- x_ready = (!y_valid || y_ready) && !flushing. Combinational; never depends on x_valid.
- Storage: KERNEL_H-1 line buffers of IMG_WIDTH x W bits plus a KERNEL_H x KERNEL_W window register.
- Pad: neighbours outside the image read as 0. No wrap between rows or frames.
- Output for centre (r,c) is computed when the stream reaches index r*IMG_WIDTH + c + D, where D = (KERNEL_H/2)*IMG_WIDTH + KERNEL_W/2. It is registered on that same edge (y_valid=1 the next cycle). The first D accepted pixels of a frame produce no output.
- Flush:
  - After the last pixel of a frame (index IMG_WIDTH*IMG_HEIGHT-1) is accepted, enter flushing.
  - x_ready=0 while flushing.
  - Internally advance D zero pixels, each advance gated by (!y_valid || y_ready), producing the remaining D outputs.
  - Then clear counters and return to accepting the next frame.
- Exactly IMG_WIDTH*IMG_HEIGHT outputs per frame; y_valid=0 when idle.
- Arithmetic:
  - Pixels zero-extended to signed.
  - Products signed 2W+1 bits.
  - Accumulator signed 2W+1+clog2(KERNEL_H*KERNEL_W) bits; no intermediate overflow.
  - sum >>> W_FRAC (arithmetic).
  - Clamp: <0 gives 0; >2^W-1 gives 2^W-1.
  - No other normalisation; a box blur overflows unless the coefficients carry W_FRAC scaling.
- Simultaneous output transfer and new input in the same cycle is allowed (full throughput: 1 pixel/clock).
- Counters wrap at IMG_WIDTH (column) and IMG_HEIGHT (row).

Test Plan:
Bench uses IMG_WIDTH=8, IMG_HEIGHT=6 unless noted; y_ready=1 unless noted.
- Identity kernel (centre 1, others 0), ramp image x=index mod 256 -> y equals x pixel-for-pixel; first y_valid one cycle after the accept of index IMG_WIDTH+1; 48 outputs total.
- Edge kernel (-1 ring, centre 8), constant 100 image -> interior 0; edge non-corner 800-500=300 clamps to 255; corner 800-300=500 clamps to 255.
- Edge kernel on a single 200 pixel at (2,3), rest 0 -> out(2,3)=255; its 8 neighbours 0 (negative clamps); all other outputs 0.
- Backpressure: repeat the identity test with y_ready pseudo-random 50% and x_valid gaps -> identical output sequence, no drops or duplicates, y_data stable while stalled, x_ready=0 during the flush.
- Sharpen kernel (0,-1,0/-1,5,-1/0,-1,0) with W_FRAC=0, constant 50 -> interior 50; edges 100; corners 150.
- Reset asserted mid-frame after 20 inputs, then a full new frame -> y_valid=0 immediately, no stale pixels, the new frame exact as in the identity test. Then two back-to-back frames -> 96 outputs, second frame unaffected by the first.

Source files
------------

// File: rtl/convolution_filter.sv
// Streaming 2-D convolution with zero padding and saturating output.
// One unsigned pixel in per handshake (raster order), one pixel out per
// pixel in. A frame ends with a self-timed flush of D zero pixels that
// drains the window so every centre gets its output.
module convolution_filter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int KERNEL_H   = 3,
    parameter int KERNEL_W   = 3,
    parameter int W          = 8,
    parameter int W_FRAC     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic [W-1:0]        x_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [W-1:0]        y_data,
    input  logic signed [W-1:0] kernel [KERNEL_H][KERNEL_W]
);

    localparam int HK    = KERNEL_H / 2;
    localparam int HW    = KERNEL_W / 2;
    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int D     = HK * IMG_WIDTH + HW;
    localparam int PW    = $clog2(NPIX + D + 1);
    localparam int CW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PRW   = 2 * W + 1;
    localparam int AW    = PRW + $clog2(KERNEL_H * KERNEL_W);
    localparam int LBN   = (KERNEL_H > 1) ? KERNEL_H - 1 : 1;
    localparam bit HAS_FLUSH = (D > 0);

    localparam logic [PW-1:0] POS_LAST_IN = PW'(NPIX - 1);
    localparam logic [PW-1:0] POS_LAST    = PW'(NPIX + D - 1);
    localparam logic [PW-1:0] POS_D       = PW'(D);
    localparam logic [CW-1:0] COL_LAST    = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_HEIGHT - 1);
    localparam logic signed [AW-1:0] PIX_MAX = AW'((1 << W) - 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t r_state, w_state_nxt;

    // stream position within the frame (input pixels plus flush pixels)
    logic [PW-1:0] r_pos;
    logic [CW-1:0] r_col;
    // coordinates of the centre whose output is produced on the next advance
    logic [RW-1:0] r_crow;
    logic [CW-1:0] r_ccol;

    logic          r_y_valid;
    logic [W-1:0]  r_y_data;

    logic          w_room, w_acc_in, w_flush_step, w_adv, w_emit, w_frame_end;
    logic [W-1:0]  w_pix_in;

    logic [W-1:0]  r_lb   [LBN][IMG_WIDTH];
    logic [W-1:0]  r_win  [KERNEL_H][KERNEL_W];
    logic [W-1:0]  w_nwin [KERNEL_H][KERNEL_W];
    logic [W-1:0]  w_col  [KERNEL_H];

    logic [W-1:0]          w_tap;
    logic signed [PRW-1:0] w_prod;
    logic signed [AW-1:0]  w_acc, w_shift;
    logic [W-1:0]          w_clamp;

    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;

    // the output register can take a new result this cycle
    assign w_room      = !r_y_valid || y_ready;
    assign w_acc_in    = x_valid && x_ready;
    assign w_adv       = w_acc_in || w_flush_step;
    assign w_emit      = w_adv && (r_pos >= POS_D);
    assign w_frame_end = w_adv && (r_pos == POS_LAST);
    // flush pixels are zeros; they land outside the image and are masked anyway
    assign w_pix_in    = (r_state == ST_FLUSH) ? '0 : x_data;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: flush after the last input pixel, back to run after D steps
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (HAS_FLUSH && w_acc_in && r_pos == POS_LAST_IN) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_room && r_pos == POS_LAST) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: input handshake and internal flush advance
    always_comb begin
        x_ready      = 1'b0;
        w_flush_step = 1'b0;
        case (r_state)
            ST_RUN:   x_ready      = w_room;
            ST_FLUSH: w_flush_step = w_room;
            default:  x_ready      = 1'b0;
        endcase
    end

    // stream and centre counters; all cleared at the end of each frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos  <= '0;
            r_col  <= '0;
            r_crow <= '0;
            r_ccol <= '0;
        end else if (w_frame_end) begin
            r_pos  <= '0;
            r_col  <= '0;
            r_crow <= '0;
            r_ccol <= '0;
        end else if (w_adv) begin
            r_pos <= r_pos + PW'(1);
            r_col <= (r_col == COL_LAST) ? '0 : r_col + CW'(1);
            if (w_emit) begin
                if (r_ccol == COL_LAST) begin
                    r_ccol <= '0;
                    r_crow <= (r_crow == ROW_LAST) ? '0 : r_crow + RW'(1);
                end else begin
                    r_ccol <= r_ccol + CW'(1);
                end
            end
        end
    end

    // next window: shift left, new column on the right. Row k of the new
    // column is the pixel (KERNEL_H-1-k) rows above the incoming one.
    for (genvar gk = 0; gk < KERNEL_H; gk++) begin : g_row
        if (gk == KERNEL_H - 1) begin : g_new
            assign w_col[gk] = w_pix_in;
        end else begin : g_old
            assign w_col[gk] = r_lb[KERNEL_H-2-gk][r_col];
        end
        for (genvar gj = 0; gj < KERNEL_W; gj++) begin : g_tap
            if (gj < KERNEL_W - 1) begin : g_sh
                assign w_nwin[gk][gj] = r_win[gk][gj+1];
            end else begin : g_in
                assign w_nwin[gk][gj] = w_col[gk];
            end
        end
    end

    // line buffers: a cascade of one-row delays addressed by the column
    if (KERNEL_H > 1) begin : g_lb
        // line buffer write on every advance (storage only, no reset needed)
        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_lb[0][r_col] <= w_pix_in;
                for (int m = 1; m < LBN; m++) r_lb[m][r_col] <= r_lb[m-1][r_col];
            end
        end
    end

    // window register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < KERNEL_H; k++)
                for (int j = 0; j < KERNEL_W; j++)
                    r_win[k][j] <= '0;
        end else if (w_adv) begin
            r_win <= w_nwin;
        end
    end

    // multiply-accumulate over the next window; taps outside the image read
    // as zero, which also hides stale data from other rows and frames
    always_comb begin : p_mac
        int nr, nc;
        w_acc  = '0;
        w_tap  = '0;
        w_prod = '0;
        nr     = 0;
        nc     = 0;
        for (int k = 0; k < KERNEL_H; k++) begin
            for (int j = 0; j < KERNEL_W; j++) begin
                nr = int'(r_crow) + k - HK;
                nc = int'(r_ccol) + j - HW;
                if (nr >= 0 && nr < IMG_HEIGHT && nc >= 0 && nc < IMG_WIDTH)
                    w_tap = w_nwin[k][j];
                else
                    w_tap = '0;
                w_prod = PRW'($signed({1'b0, w_tap})) * PRW'(kernel[k][j]);
                w_acc  = w_acc + AW'(w_prod);
            end
        end
    end

    // fixed-point scaling then saturation to the unsigned pixel range
    always_comb begin
        w_shift = w_acc >>> W_FRAC;
        if (w_shift[AW-1])         w_clamp = '0;
        else if (w_shift > PIX_MAX) w_clamp = '1;
        else                       w_clamp = w_shift[W-1:0];
    end

    // output register: load on emit, drop valid once taken downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
        end else if (w_emit) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_clamp;
        end else if (y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_convolution_filter.sv
// Bench for convolution_filter: table of kernel/image/backpressure cases with
// hand-derived spot values, every output checked against a direct
// neighbourhood-sum model, plus random frames, mid-frame reset and
// back-to-back frames.
module tb_convolution_filter;

    localparam int IW = 8;
    localparam int IH = 6;
    localparam int N  = IW * IH;
    localparam int D  = IW + 1;
    localparam int WF = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              x_valid = 1'b0;
    logic              x_ready;
    logic [7:0]        x_data = '0;
    logic              y_valid;
    logic              y_ready = 1'b1;
    logic [7:0]        y_data;
    logic signed [7:0] kern [3][3];

    always #5 clk = ~clk;

    convolution_filter #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .KERNEL_H(3), .KERNEL_W(3), .W(8), .W_FRAC(WF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .kernel(kern)
    );

    typedef struct {
        string name;
        int    kid;
        int    iid;
        bit    bp;
        int    r;
        int    c;
        int    v;
    } vec_t;

    vec_t tbl [10];
    int   img [2][N];
    int   got [2*N];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_kernel(input int kid);
        int v;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) begin
                case (kid)
                    0:       v = (k == 1 && j == 1) ? 1 : 0;
                    1:       v = (k == 1 && j == 1) ? 8 : -1;
                    2:       v = (k == 1 && j == 1) ? 5 : ((k == 1 || j == 1) ? -1 : 0);
                    default: v = int'($urandom_range(0, 8)) - 4;
                endcase
                kern[k][j] = 8'(v);
            end
    endtask

    task automatic set_image(input int f, input int iid);
        for (int i = 0; i < N; i++)
            case (iid)
                0:       img[f][i] = i % 256;
                1:       img[f][i] = 100;
                2:       img[f][i] = (i == 2*IW + 3) ? 200 : 0;
                3:       img[f][i] = 50;
                default: img[f][i] = int'($urandom_range(0, 255));
            endcase
    endtask

    // zero-padded neighbourhood sum, shifted and clamped
    function automatic int ref_px(input int f, input int r, input int c);
        int s = 0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) begin
                int nr = r + k - 1;
                int nc = c + j - 1;
                if (nr >= 0 && nr < IH && nc >= 0 && nc < IW)
                    s += img[f][nr*IW + nc] * int'(kern[k][j]);
            end
        s = s >>> WF;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    // stream nfr frames; stop_after >= 0 stops once that many pixels went in
    task automatic run(input int nfr, input bit bp, input int stop_after);
        int   idx = 0, rcv = 0, cyc = 0, f, i, prev_d = 0;
        bit   prev_stall = 0, first = 1;
        while (rcv < nfr*N && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            y_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx < nfr*N && (!bp || $urandom_range(0, 3) != 0)) begin
                x_valid = 1'b1;
                x_data  = 8'(img[idx / N][idx % N]);
            end else begin
                x_valid = 1'b0;
                x_data  = '0;
            end
            #1;
            if (prev_stall) begin
                check("stall_hold_valid", int'(y_valid), 1);
                check("stall_hold_data", int'(y_data), prev_d);
            end
            if (first && y_valid) begin
                check("first_output_latency", idx, D + 1);
                first = 0;
            end
            f = rcv / N;
            if (idx >= (f+1)*N && rcv + int'(y_valid) < (f+1)*N)
                check("x_ready_in_flush", int'(x_ready), 0);
            if (y_valid && y_ready) begin
                i = rcv % N;
                check($sformatf("pix f%0d r%0d c%0d", f, i / IW, i % IW),
                      int'(y_data), ref_px(f, i / IW, i % IW));
                got[rcv] = int'(y_data);
                rcv++;
            end
            if (x_valid && x_ready) idx++;
            prev_stall = y_valid && !y_ready;
            prev_d     = int'(y_data);
            if (stop_after >= 0 && idx >= stop_after) break;
        end
        x_valid = 1'b0;
        y_ready = 1'b1;
        if (stop_after < 0) begin
            check("output_count", rcv, nfr*N);
            repeat (2) @(negedge clk);
            #1 check("idle_no_valid", int'(y_valid), 0);
        end
    endtask

    initial begin
        tbl[0] = '{"identity_ramp",        0, 0, 1'b0, 5, 7, 47};
        tbl[1] = '{"edge_const_interior",  1, 1, 1'b0, 2, 3, 0};
        tbl[2] = '{"edge_const_side",      1, 1, 1'b0, 0, 3, 255};
        tbl[3] = '{"edge_const_corner",    1, 1, 1'b0, 0, 0, 255};
        tbl[4] = '{"edge_impulse_centre",  1, 2, 1'b0, 2, 3, 255};
        tbl[5] = '{"edge_impulse_nbr",     1, 2, 1'b0, 1, 2, 0};
        tbl[6] = '{"identity_backpressure",0, 0, 1'b1, 3, 4, 28};
        tbl[7] = '{"sharpen_interior",     2, 3, 1'b0, 2, 2, 50};
        tbl[8] = '{"sharpen_edge",         2, 3, 1'b0, 0, 4, 100};
        tbl[9] = '{"sharpen_corner",       2, 3, 1'b0, 5, 7, 150};

        set_kernel(0);
        repeat (3) @(negedge clk);
        #1;
        check("reset_y_valid", int'(y_valid), 0);
        check("reset_y_data", int'(y_data), 0);
        check("reset_x_ready", int'(x_ready), 1);
        @(negedge clk) rst_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            set_kernel(tbl[t].kid);
            set_image(0, tbl[t].iid);
            run(1, tbl[t].bp, -1);
            check(tbl[t].name, got[tbl[t].r*IW + tbl[t].c], tbl[t].v);
        end

        // random kernels and images, alternating backpressure
        for (int t = 0; t < 4; t++) begin
            set_kernel(9);
            set_image(0, 4);
            run(1, bit'(t % 2), -1);
        end

        // reset mid-frame, then a clean identity frame
        set_kernel(0);
        set_image(0, 0);
        run(1, 1'b0, 20);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midreset_y_valid", int'(y_valid), 0);
        check("midreset_y_data", int'(y_data), 0);
        @(negedge clk) rst_n = 1'b1;
        run(1, 1'b0, -1);
        check("after_reset_pix0", got[0], 0);
        check("after_reset_last", got[N-1], N-1);

        // two back-to-back frames with different content
        set_image(0, 0);
        set_image(1, 4);
        run(2, 1'b1, -1);
        check("b2b_frame1_first", got[N], img[1][0]);
        check("b2b_frame1_last", got[2*N-1], img[1][N-1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
